// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-select sequential adder.
package csa_pkg;
  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} csa_state_e;

  // Signed overflow: operands of equal sign producing a result of the other sign.
  function automatic logic signed_ovf(input logic a_sign, input logic b_sign, input logic s_msb);
    return (a_sign == b_sign) && (s_msb != a_sign);
  endfunction
endpackage

// File: rtl/csa_slice2.sv
// 2-bit carry-select slice: produces sum and carry-out for both carry-in hypotheses.
module csa_slice2
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] sum_c0,
  output logic               cout_c0,
  output logic [SLICE_W-1:0] sum_c1,
  output logic               cout_c1
);
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  logic [1:0] b0_h0, b0_h1, b1_h0, b1_h1;

  assign b0_h0 = fa(a[0], b[0], 1'b0);
  assign b0_h1 = fa(a[0], b[0], 1'b1);
  assign b1_h0 = fa(a[1], b[1], 1'b0);
  assign b1_h1 = fa(a[1], b[1], 1'b1);

  // Bit 1 is picked by bit 0's carry under each hypothesis.
  assign sum_c0  = {b0_h0[1] ? b1_h1[0] : b1_h0[0], b0_h0[0]};
  assign cout_c0 =  b0_h0[1] ? b1_h1[1] : b1_h0[1];
  assign sum_c1  = {b0_h1[1] ? b1_h1[0] : b1_h0[0], b0_h1[0]};
  assign cout_c1 =  b0_h1[1] ? b1_h1[1] : b1_h0[1];
endmodule

// File: rtl/csa_seq_ctrl.sv
// Sequential add/sub: walks a 2-bit carry-select slice over the operands, LSB digit first.
module csa_seq_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(DIGITS) + 1;

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("csa_seq_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  csa_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, res, res_nxt, b_eff;
  logic             a_sign, b_sign, cout_r, ovf_r;
  logic             accept, last;

  logic [SLICE_W-1:0] sum_c0, sum_c1, sel_sum;
  logic               cout_c0, cout_c1, sel_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(DIGITS - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign b_eff = sub ? ~b : b;

  csa_slice2 u_slice (
    .a       (a_reg[SLICE_W-1:0]),
    .b       (b_reg[SLICE_W-1:0]),
    .sum_c0  (sum_c0),
    .cout_c0 (cout_c0),
    .sum_c1  (sum_c1),
    .cout_c1 (cout_c1)
  );

  assign sel_sum  = carry ? sum_c1  : sum_c0;
  assign sel_cout = carry ? cout_c1 : cout_c0;

  // New digit enters at the MSB so the result lands aligned after DIGITS steps.
  generate
    if (WIDTH == SLICE_W) begin : g_one_digit
      assign res_nxt = sel_sum;
    end else begin : g_multi_digit
      assign res_nxt = {sel_sum, res[WIDTH-1:SLICE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_reg  <= a;
      b_reg  <= b_eff;
      carry  <= sub | cin;
      cnt    <= '0;
      a_sign <= a[WIDTH-1];
      b_sign <= b_eff[WIDTH-1];
    end else if (state == RUN) begin
      res   <= res_nxt;
      a_reg <= a_reg >> SLICE_W;
      b_reg <= b_reg >> SLICE_W;
      carry <= sel_cout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        cout_r <= sel_cout;
        ovf_r  <= signed_ovf(a_sign, b_sign, sel_sum[SLICE_W-1]);
      end
    end
  end

  assign sum  = res;
  assign cout = cout_r;
  assign ovf  = ovf_r;
endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Randomized scoreboard bench for csa_seq_ctrl against an integer-arithmetic reference.
module tb_csa_seq_ctrl;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  csa_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin, input logic tsub);
    exp_t r;
    int ua, ub, sa, sb, u, s;
    ua = ta; ub = tb_;
    sa = $signed(ta); sb = $signed(tb_);
    if (tsub) begin
      u = ua - ub; s = sa - sb; r.c = (ua >= ub);
    end else begin
      u = ua + ub + int'(tcin); s = sa + sb + int'(tcin); r.c = (u > 65535);
    end
    r.s = u[W-1:0];
    r.o = (s > 32767) || (s < -32768);
    return r;
  endfunction

  // Scoreboard monitor: compares each handed-off result with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_result: got sum %0h with no expected entry", sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum",  32'(sum),  32'(mon_e.s));
        chk("cout", 32'(cout), 32'(mon_e.c));
        chk("ovf",  32'(ovf),  32'(mon_e.o));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin, input logic tsub, input int hold);
    int n;
    logic [W-1:0] hs;
    logic hc, ho;
    wait_ready();
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    exp_q.push_back(model(ta, tb_, tcin, tsub));
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("busy_run", 32'({busy, in_ready}), 32'b10);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'd8);
    hs = sum; hc = cout; ho = ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_state", 32'({out_valid, in_ready}), 32'b10);
      chk("hold_data", 32'({hs, hc, ho}), 32'({sum, cout, ovf}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_drain", 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("reset_hs",  32'({in_ready, out_valid, busy}), 32'b100);
    chk("reset_out", 32'({sum, cout, ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    do_op(16'h4321, 16'h1111, 1'b0, 1'b0, 5);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    // Abort on the 3rd RUN cycle; the aborted op produces no result.
    wait_ready();
    a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_hs",  32'({in_ready, out_valid, busy}), 32'b100);
    chk("abort_out", 32'({sum, cout, ovf}), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csa_seq_ctrl.md
Name: csa_seq_ctrl

Overview:
Multi-cycle sequencer that adds or subtracts two WIDTH-bit operands by stepping a 2-bit carry-select slice across the operands, LSB digit first, one digit per clock.
- The slice precomputes both carry hypotheses for each digit.
- The controller resolves the real carry, shifts in the selected sum, and forwards the selected carry-out to the next digit.
- The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

Parameters:
WIDTH, 16, operand/result width; must be even and >= 2 (elaboration error otherwise)
DIGITS, WIDTH/2, localparam; number of 2-bit digits processed per operation
CNT_W, $clog2(DIGITS)+1, localparam; digit counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operation (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = A - B, 0 = A + B + cin
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out; for sub, 1 = no borrow
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, active-low):
  - Forces state IDLE, counter 0, carry 0, all operand/result registers 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Reset mid-operation aborts the operation with no result; the first op after release is fully correct.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept on the edge where in_valid && in_ready. At that edge:
    - latch a_reg = a
    - latch b_reg = sub ? ~b : b
    - set carry = sub ? 1 : cin
    - set cnt = 0
    - latch sign bits a[WIDTH-1] and b_eff[WIDTH-1]
  - Go to RUN.
- RUN, each cycle:
  - The slice receives a_reg[1:0] and b_reg[1:0].
  - Select the carry=1 or carry=0 result set using the registered carry.
  - Shift the selected 2-bit sum into the result register from the MSB end (result >> 2, new digit in [WIDTH-1:WIDTH-2]).
  - Shift a_reg and b_reg right by 2.
  - carry <= selected slice carry-out; cnt <= cnt + 1.
  - When cnt == DIGITS-1, go to DONE on that edge.
- Latency: out_valid rises DIGITS clock edges after the accept edge (8 for WIDTH=16). Fixed and data-independent.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable until out_ready.
  - cout = final carry.
  - ovf = (a_sign == b_eff_sign) && (sum[WIDTH-1] != a_sign).
  - On the edge with out_ready=1, go to IDLE; in_ready rises the following cycle.
  - No same-cycle drain-and-accept.
- Ignored inputs:
  - in_valid and operand changes while not in IDLE are ignored (in_ready=0).
  - out_ready outside DONE has no effect.
- sum, cout and ovf are registered outputs. They keep the last result through IDLE until the next DONE. Intermediate RUN values are not guaranteed to the consumer.
- Arithmetic is modulo 2^WIDTH. The carry out of the MSB is not part of sum.
- No combinational path from any input to any output, except through registered state.

Decomposition:
- Package csa_pkg holds:
  - typedef enum of the 3 states
  - localparam SLICE_W = 2
  - ovf helper function
- Sub-module csa_slice2 (combinational):
  - inputs: a[1:0], b[1:0]
  - outputs: sum_c0[1:0], cout_c0, sum_c1[1:0], cout_c1
  - built from 4 full adders plus carry-select muxes
  - instantiated once inside csa_seq_ctrl
- The controller owns all registers, the FSM and the result selection.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x0001, cin=0, sub=0 -> sum=0x1235, cout=0, ovf=0; out_valid exactly 8 edges after accept; a=0x00FF, b=0x0000, cin=1 -> sum=0x0100.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 8 digits).
3. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
5. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> out_valid, sum, cout and ovf stay stable and no accept occurs; assert out_ready -> in_ready=1 next cycle, and the next op (0x0001+0x0001) gives 0x0002.
6. Drop rst_n on the 3rd RUN cycle -> out_valid=0, in_ready=1, sum=0 immediately (asynchronous); release, then 0xAAAA+0x5555 -> sum=0xFFFF, cout=0, ovf=0.
